argmax_classifier: RTL and testbench

//  Sequential argmax over NUM_CLASSES output-layer scores; final stage of the MNIST datapath after the dense-layer MACs.

---
 rtl/argmax_classifier_if.sv | 30 +++
 rtl/argmax_classifier.sv | 160 ++++++++++++++++
 tb/tb_argmax_classifier.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/argmax_classifier_if.sv
// Score-vector input and classification result bundle for argmax_classifier.
interface argmax_classifier_if #(
  parameter int unsigned NUM_CLASSES  = 10,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH = 4
);

  logic [NUM_CLASSES*RESULT_WIDTH-1:0] data_in;
  logic                                in_valid;
  logic                                in_ready;
  logic [OUTPUT_WIDTH-1:0]             classfication_out;
  logic [RESULT_WIDTH-1:0]             max_out;
  logic [RESULT_WIDTH-1:0]             margin_out;
  logic                                out_valid;
  logic                                out_ready;
  logic                                busy;

  // Producer/consumer side: supplies scores and accepts results.
  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, classfication_out, max_out, margin_out, out_valid, busy
  );

  // Classifier side.
  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, classfication_out, max_out, margin_out, out_valid, busy
  );

endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over a captured score vector: one class compared per cycle,
// reporting winning index, winning score and top-1/top-2 margin.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES  = 10,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH = 4,
  parameter bit          SIGNED_CMP   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  argmax_classifier_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [RESULT_WIDTH-1:0] SCORE_MIN =
    SIGNED_CMP ? {1'b1, {(RESULT_WIDTH-1){1'b0}}} : '0;
  localparam logic [OUTPUT_WIDTH-1:0] LAST_IDX = OUTPUT_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [RESULT_WIDTH-1:0] scores_q [NUM_CLASSES];
  logic [RESULT_WIDTH-1:0] scores_d [NUM_CLASSES];
  logic [RESULT_WIDTH-1:0] best_q, best_d;
  logic [RESULT_WIDTH-1:0] second_q, second_d;
  logic [OUTPUT_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [OUTPUT_WIDTH-1:0] idx_q, idx_d;
  logic [OUTPUT_WIDTH-1:0] class_q, class_d;
  logic [RESULT_WIDTH-1:0] max_q, max_d;
  logic [RESULT_WIDTH-1:0] margin_q, margin_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic [RESULT_WIDTH-1:0] cur_score;

  // Strict greater-than in the configured number format.
  function automatic logic score_gt(input logic [RESULT_WIDTH-1:0] a,
                                    input logic [RESULT_WIDTH-1:0] b);
    if (SIGNED_CMP) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Next-state, scan datapath and registered-output values.
  always_comb begin
    state_d     = state_q;
    scores_d    = scores_q;
    best_d      = best_q;
    second_d    = second_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    class_d     = class_q;
    max_d       = max_q;
    margin_d    = margin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cur_score   = scores_q[idx_q[IDX_W-1:0]];

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            scores_d[k] = bus.data_in[k*RESULT_WIDTH +: RESULT_WIDTH];
          end
          best_d     = bus.data_in[RESULT_WIDTH-1:0];
          best_idx_d = '0;
          second_d   = SCORE_MIN;
          idx_d      = OUTPUT_WIDTH'(1);
          state_d    = ST_SCAN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_SCAN: begin
        // Strict compares keep the lowest index on ties; a tie still feeds second.
        if (score_gt(cur_score, best_q)) begin
          second_d   = best_q;
          best_d     = cur_score;
          best_idx_d = idx_q;
        end else if (score_gt(cur_score, second_q)) begin
          second_d = cur_score;
        end

        if (idx_q == LAST_IDX) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          class_d     = best_idx_d;
          max_d       = best_d;
          // best >= second always, so the modular difference is the true margin.
          margin_d    = best_d - second_d;
        end else begin
          idx_d = idx_q + OUTPUT_WIDTH'(1);
        end
      end

      ST_DONE: begin
        if (bus.out_ready && out_valid_q) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      scores_q    <= '{default: '0};
      best_q      <= '0;
      second_q    <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      class_q     <= '0;
      max_q       <= '0;
      margin_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scores_q    <= scores_d;
      best_q      <= best_d;
      second_q    <= second_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      class_q     <= class_d;
      max_q       <= max_d;
      margin_q    <= margin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.busy              = busy_q;
  assign bus.classfication_out = class_q;
  assign bus.max_out           = max_q;
  assign bus.margin_out        = margin_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: signed and unsigned instances.
module tb_argmax_classifier;

  localparam int unsigned NC = 10;
  localparam int unsigned RW = 32;
  localparam int unsigned OW = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] sc [NC];

  argmax_classifier_if #(.NUM_CLASSES(NC), .RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW)) if_s ();
  argmax_classifier_if #(.NUM_CLASSES(NC), .RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW)) if_u ();

  argmax_classifier #(
    .NUM_CLASSES(NC), .RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW), .SIGNED_CMP(1'b1)
  ) u_dut_s (
    .clk(clk), .rst(rst), .bus(if_s)
  );

  argmax_classifier #(
    .NUM_CLASSES(NC), .RESULT_WIDTH(RW), .OUTPUT_WIDTH(OW), .SIGNED_CMP(1'b0)
  ) u_dut_u (
    .clk(clk), .rst(rst), .bus(if_u)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present sc[] to the signed instance for one accepting cycle, then scramble data_in.
  task automatic send_s();
    for (int k = 0; k < NC; k++) if_s.data_in[k*RW +: RW] = sc[k];
    if_s.in_valid = 1'b1;
    tick();
    if_s.in_valid = 1'b0;
    if_s.data_in  = '1;
  endtask

  task automatic wait_s(output int n);
    n = 0;
    while (!if_s.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Full single-vector transaction on the signed instance with a one-cycle handshake.
  task automatic run_s(input string tag, input logic [OW-1:0] e_cls,
                       input logic [RW-1:0] e_max, input logic [RW-1:0] e_mrg);
    int n;
    send_s();
    check({tag, "_in_ready_scan"}, 64'(if_s.in_ready), 64'd0);
    check({tag, "_busy_scan"}, 64'(if_s.busy), 64'd1);
    wait_s(n);
    check({tag, "_latency"}, 64'(n), 64'd9);
    check({tag, "_class"}, 64'(if_s.classfication_out), 64'(e_cls));
    check({tag, "_max"}, 64'(if_s.max_out), 64'(e_max));
    check({tag, "_margin"}, 64'(if_s.margin_out), 64'(e_mrg));
    if_s.out_ready = 1'b1;
    tick();
    if_s.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(if_s.out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(if_s.in_ready), 64'd1);
    check({tag, "_class_held"}, 64'(if_s.classfication_out), 64'(e_cls));
  endtask

  initial begin
    int n;
    int got;
    int cyc;
    int t [3];

    rst = 1'b0;
    if_s.in_valid = 1'b0; if_s.out_ready = 1'b0; if_s.data_in = '0;
    if_u.in_valid = 1'b0; if_u.out_ready = 1'b0; if_u.data_in = '0;
    tick(); tick(); tick();

    // Reset state
    check("rst_in_ready", 64'(if_s.in_ready), 64'd1);
    check("rst_out_valid", 64'(if_s.out_valid), 64'd0);
    check("rst_busy", 64'(if_s.busy), 64'd0);
    check("rst_class", 64'(if_s.classfication_out), 64'd0);
    check("rst_max", 64'(if_s.max_out), 64'd0);
    check("rst_margin", 64'(if_s.margin_out), 64'd0);
    check("rst_u_in_ready", 64'(if_u.in_ready), 64'd1);
    rst = 1'b1;
    tick();

    // 1: ascending winner at the last index
    sc = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd0, 32'd2, 32'd7, 32'd4, 32'd6, 32'd9};
    run_s("t1", 4'd9, 32'd9, 32'd1);

    // 2: all negative scores
    sc = '{32'hFFFF_FFEC, 32'hFFFF_FFF1, 32'hFFFF_FFF4, 32'hFFFF_FFE2, 32'hFFFF_FFFD,
           32'hFFFF_FFCE, 32'hFFFF_FFF5, 32'hFFFF_FFF6, 32'hFFFF_FFD8, 32'hFFFF_FF9C};
    run_s("t2", 4'd4, 32'hFFFF_FFFD, 32'd7);

    // 3: tie between classes 2 and 6
    sc = '{32'd0, 32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd100, 32'd0, 32'd0, 32'd0};
    run_s("t3", 4'd2, 32'd100, 32'd0);

    // 3b: every score at the signed minimum
    for (int k = 0; k < NC; k++) sc[k] = 32'h8000_0000;
    run_s("t3b", 4'd0, 32'h8000_0000, 32'd0);

    // 4: back-pressure with the winner at index 0
    sc = '{32'd50, 32'd10, 32'd20, 32'd30, 32'd40, 32'd45, 32'd0, 32'd5, 32'd15, 32'd25};
    send_s();
    wait_s(n);
    check("t4_latency", 64'(n), 64'd9);
    if_s.data_in  = '0;
    if_s.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(if_s.out_valid), 64'd1);
      check("t4_hold_in_ready", 64'(if_s.in_ready), 64'd0);
      check("t4_hold_class", 64'(if_s.classfication_out), 64'd0);
      check("t4_hold_max", 64'(if_s.max_out), 64'd50);
      check("t4_hold_margin", 64'(if_s.margin_out), 64'd5);
      tick();
    end
    if_s.in_valid  = 1'b0;
    if_s.out_ready = 1'b1;
    tick();
    if_s.out_ready = 1'b0;
    check("t4_release_in_ready", 64'(if_s.in_ready), 64'd1);
    check("t4_release_out_valid", 64'(if_s.out_valid), 64'd0);
    tick(); tick();
    check("t4_idle_busy", 64'(if_s.busy), 64'd0);
    check("t4_idle_in_ready", 64'(if_s.in_ready), 64'd1);

    // 5: reset during SCAN cycle 4, then a fresh vector
    sc = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    send_s();
    tick(); tick(); tick();
    check("t5_busy_before_rst", 64'(if_s.busy), 64'd1);
    rst = 1'b0;
    tick();
    check("t5_rst_out_valid", 64'(if_s.out_valid), 64'd0);
    check("t5_rst_in_ready", 64'(if_s.in_ready), 64'd1);
    check("t5_rst_busy", 64'(if_s.busy), 64'd0);
    check("t5_rst_class", 64'(if_s.classfication_out), 64'd0);
    check("t5_rst_max", 64'(if_s.max_out), 64'd0);
    check("t5_rst_margin", 64'(if_s.margin_out), 64'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    check("t5_no_late_result", 64'(if_s.out_valid), 64'd0);
    sc = '{32'hFFFF_FFFB, 32'd12, 32'd4, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd12};
    run_s("t5_after", 4'd1, 32'd12, 32'd0);

    // 6: unsigned vs signed interpretation of all-ones
    sc = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_s("t6_signed", 4'd0, 32'd1, 32'd1);

    for (int k = 0; k < NC; k++) if_u.data_in[k*RW +: RW] = sc[k];
    if_u.in_valid  = 1'b1;
    if_u.out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (if_u.out_valid) begin
        t[got] = cyc;
        got++;
        check("t6_u_class", 64'(if_u.classfication_out), 64'd3);
        check("t6_u_max", 64'(if_u.max_out), 64'hFFFF_FFFF);
        check("t6_u_margin", 64'(if_u.margin_out), 64'hFFFF_FFFE);
      end
    end
    if_u.in_valid = 1'b0;
    check("t6_b2b_count", 64'(got), 64'd3);
    if (got == 3) begin
      check("t6_b2b_period0", 64'(t[1] - t[0]), 64'd11);
      check("t6_b2b_period1", 64'(t[2] - t[1]), 64'd11);
    end
    tick();
    if_u.out_ready = 1'b0;
    check("t6_u_in_ready_end", 64'(if_u.in_ready), 64'd1);
    check("t6_u_out_valid_end", 64'(if_u.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
